sc_statemachine_result_unloader: RTL and testbench
==================================================

// Module: sc_statemachine_result_unloader
// PURPOSE
//  Reverse path of the image-load interface: reads the CNN result buffer row by row and
//  streams it out bit-serially to the host. Drives active-low per-row read strobes into the
//  row buffer, captures the selected row, then shifts it out one bit per i_BIT_TICK.
//  Sits between the result row registers and the serial output pad logic.
// PARAMETERS
//  N_ROWS    8      rows in the result buffer (2..15)
//  DATA_W    8      bits per row
//  CMD_READ  2'b01  i_CMD code for READ RESULT
// PORTS
//  i_CLOCK        in   1       system clock, all logic on rising edge
//  i_RESET        in   1       asynchronous reset, active-high
//  i_CMD          in   2       host command; transfer runs only while == CMD_READ
//  i_START        in   1       1-cycle start request, sampled in IDLE only
//  i_BIT_TICK     in   1       1-cycle pulse: advance one serial bit
//  i_ROW_DATA     in   DATA_W  row contents, valid the cycle after o_RD_n strobe
//  o_RD_n         out  N_ROWS  active-low row read strobes, one-hot-low, all 1 when inactive
//  o_ROW          out  4       current row index
//  o_BIT_COUNT    out  7       bits sent in current row (0..DATA_W, +1 with parity)
//  o_SDATA        out  1       serial data, MSB first
//  o_SVALID       out  1       high while o_SDATA carries a valid bit
//  o_BUSY         out  1       high in every state except IDLE
//  o_DONE         out  1       1-cycle pulse after last row's last bit
// BEHAVIOUR
//  Reset: state IDLE, o_RD_n all 1, o_ROW=0, o_BIT_COUNT=0, o_SDATA=0, o_SVALID=0,
//   o_BUSY=0, o_DONE=0, shift register cleared.
//  States (registered, Moore outputs):
//   IDLE   : i_START && i_CMD==CMD_READ -> SELECT; row<=0, bit count<=0.
//   SELECT : o_RD_n[o_ROW]=0 for exactly this cycle -> LATCH.
//   LATCH  : shift reg <= i_ROW_DATA; bit count<=0 -> SHIFT.
//   SHIFT  : o_SVALID=1, o_SDATA=shift reg MSB. On i_BIT_TICK: shift left (zero fill),
//            bit count+1; when count reaches DATA_W -> NEXT. No tick -> hold.
//   NEXT   : o_ROW==N_ROWS-1 -> DONE; else row+1 -> SELECT.
//   DONE   : o_DONE=1 for one cycle, o_ROW<=0 -> IDLE.
//  Latency: start to first valid bit = 3 cycles (SELECT, LATCH, SHIFT).
//  Tick outside SHIFT is ignored (no buffering). Tick on last bit: o_SVALID drops next cycle.
//  i_START while busy is ignored; no re-trigger, no queueing.
//  Abort: i_CMD != CMD_READ in any non-IDLE state -> IDLE next cycle; o_ROW and bit count
//   to 0, o_SVALID=0, no o_DONE pulse. Abort has priority over tick and state advance.
//  Reset mid-transfer: immediate return to reset values, strobes deasserted asynchronously.
//  Row counter never wraps: exactly N_ROWS rows per START. o_ROW width fixed at 4 bits.
// CONFIGURATION
//  UNLOADER_PARITY_EN defined: after DATA_W data bits, one extra SHIFT bit = even parity
//   (XOR of the row captured in LATCH); row ends at count DATA_W+1.
//  Not defined: exactly DATA_W bits per row, no parity logic synthesised.
// TESTING
//  Reset, START with i_CMD=2'b01, tick every 4 cycles, rows 0..7 = 8'hA5+row -> strobes
//   o_RD_n=8'hFE..8'h7F one cycle each, stream MSB-first matches rows, one o_DONE pulse.
//  START with i_CMD=2'b00 -> stays IDLE, o_BUSY=0, all o_RD_n=1.
//  Tick continuously every cycle -> 64 valid bits back-to-back per row groups, 3-cycle
//   gap (NEXT, SELECT, LATCH) between rows, o_DONE after last bit.
//  i_CMD -> 2'b10 during row 3 bit 5 -> IDLE next cycle, o_SVALID=0, o_ROW=0, no o_DONE.
//  i_RESET pulse during SELECT -> o_RD_n=8'hFF immediately, all outputs at reset values.
//  With UNLOADER_PARITY_EN, row 8'h07 -> 9 bits 0000_0111_1, o_BIT_COUNT reaches 9.

Source files
------------

// File: rtl/sc_statemachine_result_unloader_if.sv
// ----------------------------------------------------------------------------
// sc_statemachine_result_unloader_if
//
// Purpose:
//   Bundles the command/handshake, row-buffer and serial-output signals of the
//   result unloader so the design and its host side connect through one port.
//
// Parameters:
//   N_ROWS  rows in the result buffer (width of the read strobe vector)
//   DATA_W  bits per row
//
// Signals (direction as seen from the unloader, modport slave):
//   i_CMD        in   2       host command
//   i_START      in   1       1-cycle start request
//   i_BIT_TICK   in   1       1-cycle pulse, advance one serial bit
//   i_ROW_DATA   in   DATA_W  row contents from the result buffer
//   o_RD_n       out  N_ROWS  active-low one-hot row read strobes
//   o_ROW        out  4       current row index
//   o_BIT_COUNT  out  7       bits sent in the current row
//   o_SDATA      out  1       serial data, MSB first
//   o_SVALID     out  1       serial data valid
//   o_BUSY       out  1       transfer in progress
//   o_DONE       out  1       1-cycle completion pulse
//
// Modports:
//   slave   the unloader itself
//   master  the host / row buffer side that drives commands and row data
// ----------------------------------------------------------------------------
interface sc_statemachine_result_unloader_if #(
    parameter int N_ROWS = 8,
    parameter int DATA_W = 8
);
    logic [1:0]        i_CMD;
    logic              i_START;
    logic              i_BIT_TICK;
    logic [DATA_W-1:0] i_ROW_DATA;
    logic [N_ROWS-1:0] o_RD_n;
    logic [3:0]        o_ROW;
    logic [6:0]        o_BIT_COUNT;
    logic              o_SDATA;
    logic              o_SVALID;
    logic              o_BUSY;
    logic              o_DONE;

    modport slave (
        input  i_CMD, i_START, i_BIT_TICK, i_ROW_DATA,
        output o_RD_n, o_ROW, o_BIT_COUNT, o_SDATA, o_SVALID, o_BUSY, o_DONE
    );

    modport master (
        output i_CMD, i_START, i_BIT_TICK, i_ROW_DATA,
        input  o_RD_n, o_ROW, o_BIT_COUNT, o_SDATA, o_SVALID, o_BUSY, o_DONE
    );
endinterface

// File: rtl/sc_statemachine_result_unloader.sv
// ----------------------------------------------------------------------------
// sc_statemachine_result_unloader
//
// Purpose:
//   Reads the CNN result buffer one row at a time and streams each row out
//   bit-serially, MSB first, one bit per i_BIT_TICK. Each row is fetched by
//   pulsing its active-low read strobe for one cycle, capturing the row one
//   cycle later, then shifting it out. After the last row a one-cycle o_DONE
//   pulse is produced.
//
// Parameters:
//   N_ROWS    rows in the result buffer (2..15)
//   DATA_W    bits per row
//   CMD_READ  i_CMD code that enables the transfer
//
// Ports:
//   i_CLOCK   in  system clock, rising edge
//   i_RESET   in  asynchronous reset, active-high
//   bus       sc_statemachine_result_unloader_if.slave (command, row data,
//             read strobes, row/bit counters, serial data, status)
//
// Configuration:
//   UNLOADER_PARITY_EN  when defined, an even-parity bit (XOR of the captured
//                       row) is sent after the data bits of every row.
// ----------------------------------------------------------------------------
module sc_statemachine_result_unloader #(
    parameter int         N_ROWS   = 8,
    parameter int         DATA_W   = 8,
    parameter logic [1:0] CMD_READ = 2'b01
) (
    input  logic i_CLOCK,
    input  logic i_RESET,
    sc_statemachine_result_unloader_if.slave bus
);

`ifdef UNLOADER_PARITY_EN
    // The parity bit rides in the LSB of the shift register so it simply
    // falls out after the data bits.
    localparam int SH_W = DATA_W + 1;
`else
    localparam int SH_W = DATA_W;
`endif

    localparam logic [6:0]        LAST_CNT = 7'(SH_W);
    localparam logic [3:0]        LAST_ROW = 4'(N_ROWS - 1);
    localparam logic [N_ROWS-1:0] ONE_HOT  = {{(N_ROWS-1){1'b0}}, 1'b1};
    localparam logic [N_ROWS-1:0] ALL_OFF  = {N_ROWS{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_LATCH,
        S_SHIFT,
        S_NEXT,
        S_DONE
    } state_t;

    state_t            r_state;
    logic [N_ROWS-1:0] r_rdN;
    logic [3:0]        r_row;
    logic [6:0]        r_bitCount;
    logic [SH_W-1:0]   r_shift;
    logic              r_sdata;
    logic              r_svalid;
    logic              r_busy;
    logic              r_done;

    logic              w_cmdOk;
    logic              w_lastBit;
    logic [3:0]        w_nextRow;
    logic [N_ROWS-1:0] w_strobeNext;
    logic [SH_W-1:0]   w_shiftNext;
    logic [SH_W-1:0]   w_loadWord;

    // Next-value helpers used by the state machine below.
    assign w_cmdOk      = (bus.i_CMD == CMD_READ);
    assign w_lastBit    = (r_bitCount == (LAST_CNT - 7'd1));
    assign w_nextRow    = r_row + 4'd1;
    assign w_strobeNext = ~(ONE_HOT << w_nextRow);
    assign w_shiftNext  = r_shift << 1;

`ifdef UNLOADER_PARITY_EN
    assign w_loadWord = {bus.i_ROW_DATA, ^bus.i_ROW_DATA};
`else
    assign w_loadWord = bus.i_ROW_DATA;
`endif

    // Single registered state machine. All outputs are registers that are
    // given their value on the transition into the state that owns them, so
    // each output is valid for exactly the cycles the state is occupied.
    // Strobes and the done pulse default to inactive every cycle. Leaving
    // the read command aborts from any active state and takes priority over
    // ticks and normal state advance.
    always_ff @(posedge i_CLOCK or posedge i_RESET) begin
        if (i_RESET) begin
            r_state    <= S_IDLE;
            r_rdN      <= ALL_OFF;
            r_row      <= 4'd0;
            r_bitCount <= 7'd0;
            r_shift    <= '0;
            r_sdata    <= 1'b0;
            r_svalid   <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_rdN  <= ALL_OFF;
            r_done <= 1'b0;
            if (r_state != S_IDLE && !w_cmdOk) begin
                r_state    <= S_IDLE;
                r_row      <= 4'd0;
                r_bitCount <= 7'd0;
                r_shift    <= '0;
                r_sdata    <= 1'b0;
                r_svalid   <= 1'b0;
                r_busy     <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (bus.i_START && w_cmdOk) begin
                            r_state    <= S_SELECT;
                            r_row      <= 4'd0;
                            r_bitCount <= 7'd0;
                            r_rdN      <= ~ONE_HOT;
                            r_busy     <= 1'b1;
                        end
                    end
                    S_SELECT: begin
                        r_state <= S_LATCH;
                    end
                    S_LATCH: begin
                        r_shift    <= w_loadWord;
                        r_sdata    <= w_loadWord[SH_W-1];
                        r_svalid   <= 1'b1;
                        r_bitCount <= 7'd0;
                        r_state    <= S_SHIFT;
                    end
                    S_SHIFT: begin
                        if (bus.i_BIT_TICK) begin
                            r_shift    <= w_shiftNext;
                            r_bitCount <= r_bitCount + 7'd1;
                            if (w_lastBit) begin
                                r_sdata  <= 1'b0;
                                r_svalid <= 1'b0;
                                r_state  <= S_NEXT;
                            end else begin
                                r_sdata <= w_shiftNext[SH_W-1];
                            end
                        end
                    end
                    S_NEXT: begin
                        if (r_row == LAST_ROW) begin
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_row   <= w_nextRow;
                            r_rdN   <= w_strobeNext;
                            r_state <= S_SELECT;
                        end
                    end
                    S_DONE: begin
                        r_row   <= 4'd0;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.o_RD_n      = r_rdN;
    assign bus.o_ROW       = r_row;
    assign bus.o_BIT_COUNT = r_bitCount;
    assign bus.o_SDATA     = r_sdata;
    assign bus.o_SVALID    = r_svalid;
    assign bus.o_BUSY      = r_busy;
    assign bus.o_DONE      = r_done;

endmodule

// File: tb/tb_sc_statemachine_result_unloader.sv
// ----------------------------------------------------------------------------
// tb_sc_statemachine_result_unloader
//
// Directed bench for the result unloader: reset values, ignored start with a
// non-read command, full transfers with sparse and continuous ticks, abort
// mid-row and asynchronous reset during a row select. A small row-buffer
// model answers the read strobes one cycle later.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sc_statemachine_result_unloader;

    localparam int         N_ROWS   = 8;
    localparam int         DATA_W   = 8;
    localparam logic [1:0] CMD_READ = 2'b01;
`ifdef UNLOADER_PARITY_EN
    localparam int BITS = DATA_W + 1;
`else
    localparam int BITS = DATA_W;
`endif

    logic clock;
    logic reset;

    int vectorCount = 0;
    int missCount   = 0;

    logic [7:0]  rowMem [N_ROWS];
    logic [31:0] rowAcc [N_ROWS];
    logic [7:0]  strobeLog [$];
    int          validCyc [$];
    int          bitIdx;
    int          doneCount;
    int          doneCyc;
    int          firstValid;
    int          maxCount;

    sc_statemachine_result_unloader_if #(.N_ROWS(N_ROWS), .DATA_W(DATA_W)) busIf ();

    sc_statemachine_result_unloader #(
        .N_ROWS   (N_ROWS),
        .DATA_W   (DATA_W),
        .CMD_READ (CMD_READ)
    ) dut (
        .i_CLOCK (clock),
        .i_RESET (reset),
        .bus     (busIf)
    );

    // 100 MHz clock.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Row buffer model: a low strobe returns that row on the next cycle.
    always @(posedge clock) begin
        for (int i = 0; i < N_ROWS; i++) begin
            if (busIf.o_RD_n[i] === 1'b0) busIf.i_ROW_DATA <= rowMem[i];
        end
    end

    // Single comparison point: counts every vector and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drive the host-side inputs for the coming clock edge.
    task automatic applyStimulus(input logic [1:0] cmd, input logic start, input logic tick);
        busIf.i_CMD      = cmd;
        busIf.i_START    = start;
        busIf.i_BIT_TICK = tick;
    endtask

    // Advance one cycle and land 1 ns after the edge, away from it.
    task automatic stepClock();
        @(posedge clock);
        #1;
    endtask

    // Start a transfer and log strobes, valid cycles, serial bits and done
    // pulses. Cycle 1 is the first cycle after the start edge.
    task automatic runTransfer(input int tickPeriod);
        logic tick;
        strobeLog.delete();
        validCyc.delete();
        for (int r = 0; r < N_ROWS; r++) rowAcc[r] = 32'd0;
        bitIdx = 0; doneCount = 0; doneCyc = -1; firstValid = -1; maxCount = 0;
        applyStimulus(CMD_READ, 1'b1, 1'b0);
        stepClock();
        for (int cyc = 1; cyc < 2000; cyc++) begin
            tick = ((cyc % tickPeriod) == 0);
            applyStimulus(CMD_READ, 1'b0, tick);
            if (busIf.o_RD_n !== 8'hFF) strobeLog.push_back(busIf.o_RD_n);
            if (busIf.o_SVALID === 1'b1) begin
                validCyc.push_back(cyc);
                if (firstValid < 0) firstValid = cyc;
                if (tick && bitIdx < N_ROWS * BITS) begin
                    rowAcc[bitIdx / BITS] = (rowAcc[bitIdx / BITS] << 1) | 32'(busIf.o_SDATA);
                    bitIdx++;
                end
            end
            if (int'(busIf.o_BIT_COUNT) > maxCount) maxCount = int'(busIf.o_BIT_COUNT);
            if (busIf.o_DONE === 1'b1) begin
                doneCount++;
                if (doneCyc < 0) doneCyc = cyc;
            end
            if (doneCyc >= 0 && cyc >= doneCyc + 3) break;
            stepClock();
        end
        checkOutput("transfer_completed", 32'(doneCyc >= 0), 32'd1);
    endtask

    // Checks common to every complete transfer.
    task automatic checkTransfer(input string name);
        logic [7:0]  expStrobe;
        logic [31:0] expBits;
        checkOutput({name, "_strobe_count"}, 32'(strobeLog.size()), 32'(N_ROWS));
        for (int r = 0; r < N_ROWS; r++) begin
            expStrobe    = 8'hFF;
            expStrobe[r] = 1'b0;
            checkOutput($sformatf("%s_strobe_row%0d", name, r),
                        (r < strobeLog.size()) ? 32'(strobeLog[r]) : 32'hDEAD, 32'(expStrobe));
`ifdef UNLOADER_PARITY_EN
            expBits = {23'd0, rowMem[r], ^rowMem[r]};
`else
            expBits = {24'd0, rowMem[r]};
`endif
            checkOutput($sformatf("%s_bits_row%0d", name, r), rowAcc[r], expBits);
        end
        checkOutput({name, "_bits_total"}, 32'(bitIdx), 32'(N_ROWS * BITS));
        checkOutput({name, "_done_pulses"}, 32'(doneCount), 32'd1);
        checkOutput({name, "_first_valid_cycle"}, 32'(firstValid), 32'd3);
        checkOutput({name, "_max_bit_count"}, 32'(maxCount), 32'(BITS));
        checkOutput({name, "_busy_after"}, 32'(busIf.o_BUSY), 32'd0);
        checkOutput({name, "_row_after"}, 32'(busIf.o_ROW), 32'd0);
    endtask

    // Abort by leaving the read command while row 3 presents bit 5.
    task automatic runAbort();
        logic aborted;
        aborted   = 1'b0;
        doneCount = 0;
        applyStimulus(CMD_READ, 1'b1, 1'b0);
        stepClock();
        for (int cyc = 1; cyc < 300 && !aborted; cyc++) begin
            if (busIf.o_DONE === 1'b1) doneCount++;
            if (busIf.o_SVALID === 1'b1 && busIf.o_ROW == 4'd3 && busIf.o_BIT_COUNT == 7'd5) begin
                applyStimulus(2'b10, 1'b0, 1'b1);
                aborted = 1'b1;
            end else begin
                applyStimulus(CMD_READ, 1'b0, 1'b1);
            end
            stepClock();
        end
        checkOutput("abort_reached_row3_bit5", 32'(aborted), 32'd1);
        checkOutput("abort_svalid", 32'(busIf.o_SVALID), 32'd0);
        checkOutput("abort_row", 32'(busIf.o_ROW), 32'd0);
        checkOutput("abort_bit_count", 32'(busIf.o_BIT_COUNT), 32'd0);
        checkOutput("abort_busy", 32'(busIf.o_BUSY), 32'd0);
        checkOutput("abort_rd_n", 32'(busIf.o_RD_n), 32'hFF);
        for (int k = 0; k < 6; k++) begin
            applyStimulus((k < 3) ? 2'b10 : CMD_READ, 1'b0, 1'b1);
            if (busIf.o_DONE === 1'b1) doneCount++;
            stepClock();
        end
        checkOutput("abort_no_done", 32'(doneCount), 32'd0);
        checkOutput("abort_stays_idle", 32'(busIf.o_BUSY), 32'd0);
    endtask

    initial begin
        for (int r = 0; r < N_ROWS; r++) rowMem[r] = 8'hA5 + 8'(r);
`ifdef UNLOADER_PARITY_EN
        rowMem[0] = 8'h07;
`endif
        reset = 1'b1;
        busIf.i_ROW_DATA = '0;
        applyStimulus(2'b00, 1'b0, 1'b0);
        stepClock();
        stepClock();
        reset = 1'b0;
        stepClock();

        $display("[TB] reset values");
        checkOutput("reset_rd_n", 32'(busIf.o_RD_n), 32'hFF);
        checkOutput("reset_row", 32'(busIf.o_ROW), 32'd0);
        checkOutput("reset_bit_count", 32'(busIf.o_BIT_COUNT), 32'd0);
        checkOutput("reset_sdata", 32'(busIf.o_SDATA), 32'd0);
        checkOutput("reset_svalid", 32'(busIf.o_SVALID), 32'd0);
        checkOutput("reset_busy", 32'(busIf.o_BUSY), 32'd0);
        checkOutput("reset_done", 32'(busIf.o_DONE), 32'd0);

        $display("[TB] start with non-read command");
        applyStimulus(2'b00, 1'b1, 1'b0);
        stepClock();
        applyStimulus(2'b00, 1'b0, 1'b0);
        checkOutput("cmd00_busy", 32'(busIf.o_BUSY), 32'd0);
        checkOutput("cmd00_rd_n", 32'(busIf.o_RD_n), 32'hFF);
        stepClock();
        applyStimulus(CMD_READ, 1'b0, 1'b0);
        stepClock();
        stepClock();
        checkOutput("cmd00_still_idle", 32'(busIf.o_BUSY), 32'd0);

        $display("[TB] transfer, tick every 4 cycles");
        runTransfer(4);
        checkTransfer("tick4");

        $display("[TB] transfer, tick every cycle");
        runTransfer(1);
        checkTransfer("tick1");
        checkOutput("tick1_valid_cycles", 32'(validCyc.size()), 32'(N_ROWS * BITS));
        for (int r = 0; r < N_ROWS; r++) begin
            checkOutput($sformatf("tick1_row%0d_start_cycle", r),
                        (r * BITS < validCyc.size()) ? 32'(validCyc[r * BITS]) : 32'hDEAD,
                        32'(3 + r * (BITS + 3)));
        end
        checkOutput("tick1_done_cycle", 32'(doneCyc),
                    32'(3 + (N_ROWS - 1) * (BITS + 3) + BITS + 1));
`ifdef UNLOADER_PARITY_EN
        checkOutput("parity_row07_bits", rowAcc[0], 32'b0000_0111_1);
`endif

        $display("[TB] abort during row 3 bit 5");
        runAbort();

        $display("[TB] reset during select");
        applyStimulus(CMD_READ, 1'b1, 1'b0);
        stepClock();
        applyStimulus(CMD_READ, 1'b0, 1'b0);
        checkOutput("select_rd_n", 32'(busIf.o_RD_n), 32'hFE);
        checkOutput("select_busy", 32'(busIf.o_BUSY), 32'd1);
        #2 reset = 1'b1;
        #1;
        checkOutput("async_reset_rd_n", 32'(busIf.o_RD_n), 32'hFF);
        checkOutput("async_reset_busy", 32'(busIf.o_BUSY), 32'd0);
        checkOutput("async_reset_row", 32'(busIf.o_ROW), 32'd0);
        checkOutput("async_reset_svalid", 32'(busIf.o_SVALID), 32'd0);
        checkOutput("async_reset_done", 32'(busIf.o_DONE), 32'd0);
        stepClock();
        reset = 1'b0;
        stepClock();
        stepClock();
        checkOutput("post_reset_idle", 32'(busIf.o_BUSY), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
